// File: rtl/bp_be_pkg.sv
// Shared BE types for the sequential multiply pipe: op encoding and FSM states.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_mul_lo  = 2'd0,
        e_mulh    = 2'd1,
        e_mulhsu  = 2'd2,
        e_mulhu   = 2'd3
    } bp_be_mul_seq_op_e;

    typedef enum logic [1:0] {
        e_mul_seq_idle = 2'd0,
        e_mul_seq_calc = 2'd1,
        e_mul_seq_done = 2'd2
    } bp_be_mul_seq_state_e;

endpackage

// File: rtl/bp_be_pipe_mul_seq.sv
// Iterative RV64M multiplier retiring radix_bits_p multiplier bits per cycle.
// Optional early termination on an exhausted multiplier: BP_BE_MUL_SEQ_EARLY_OUT_EN.
module bp_be_pipe_mul_seq
    import bp_be_pkg::*;
#(
    parameter int width_p      = 64,
    parameter int radix_bits_p = 2,
    parameter int word_width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_and_o,
    input  bp_be_mul_seq_op_e  op_i,
    input  logic               opw_i,
    input  logic [width_p-1:0] rs1_i,
    input  logic [width_p-1:0] rs2_i,
    input  logic               flush_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int N  = width_p / radix_bits_p;
    localparam int NW = word_width_p / radix_bits_p;
    localparam int CW = $clog2(N + 1);
    localparam int AW = 2 * width_p;
    localparam logic [CW-1:0] LastN = CW'(N - 1);
    localparam logic [CW-1:0] LastW = CW'(NW - 1);

    bp_be_mul_seq_state_e state_q, state_d;
    bp_be_mul_seq_op_e    op_q;
    logic                 opw_q, neg_q, live_q;
    logic [AW-1:0]        acc_q, acc_d, mcand_q, pp, prod;
    logic [width_p-1:0]   mplier_q, mplier_d, data_q, data_d;
    logic [CW-1:0]        cnt_q;
    logic                 accept, calc_last;
    logic                 sign1, sign2;
    logic [width_p-1:0]   src1, src2, mag1, mag2;

    assign accept = v_i & ready_and_o & ~flush_i;

    // W-ops take signed low words and hand their magnitudes to the datapath.
    always_comb begin
        if (opw_i) begin
            sign1 = rs1_i[word_width_p-1];
            sign2 = rs2_i[word_width_p-1];
            src1  = {{(width_p-word_width_p){rs1_i[word_width_p-1]}}, rs1_i[word_width_p-1:0]};
            src2  = {{(width_p-word_width_p){rs2_i[word_width_p-1]}}, rs2_i[word_width_p-1:0]};
        end else begin
            sign1 = rs1_i[width_p-1] & ((op_i == e_mulh) | (op_i == e_mulhsu));
            sign2 = rs2_i[width_p-1] & (op_i == e_mulh);
            src1  = rs1_i;
            src2  = rs2_i;
        end
        mag1 = sign1 ? -src1 : src1;
        mag2 = sign2 ? -src2 : src2;
    end

    assign pp       = mcand_q * {{(AW-radix_bits_p){1'b0}}, mplier_q[radix_bits_p-1:0]};
    assign acc_d    = acc_q + pp;
    assign mplier_d = mplier_q >> radix_bits_p;
    assign prod     = neg_q ? -acc_d : acc_d;

`ifdef BP_BE_MUL_SEQ_EARLY_OUT_EN
    assign calc_last = (cnt_q == (opw_q ? LastW : LastN)) | (mplier_d == '0);
`else
    assign calc_last = (cnt_q == (opw_q ? LastW : LastN));
`endif

    always_comb begin
        if (opw_q)
            data_d = {{(width_p-word_width_p){prod[word_width_p-1]}}, prod[word_width_p-1:0]};
        else if (op_q == e_mul_lo)
            data_d = prod[width_p-1:0];
        else
            data_d = prod[AW-1:width_p];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= e_mul_seq_idle;
        else            state_q <= state_d;
    end

    // Flush wins over both completion and yumi.
    always_comb begin
        state_d = state_q;
        case (state_q)
            e_mul_seq_idle: if (accept) state_d = e_mul_seq_calc;
            e_mul_seq_calc: if (flush_i) state_d = e_mul_seq_idle;
                            else if (calc_last) state_d = e_mul_seq_done;
            e_mul_seq_done: if (flush_i | yumi_i) state_d = e_mul_seq_idle;
            default:        state_d = e_mul_seq_idle;
        endcase
    end

    always_comb begin
        ready_and_o = (state_q == e_mul_seq_idle) & live_q;
        v_o         = (state_q == e_mul_seq_done);
        data_o      = data_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            live_q   <= 1'b0;
            op_q     <= e_mul_lo;
            opw_q    <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                op_q     <= op_i;
                opw_q    <= opw_i;
                neg_q    <= sign1 ^ sign2;
                acc_q    <= '0;
                mcand_q  <= {{width_p{1'b0}}, mag1};
                mplier_q <= mag2;
                cnt_q    <= '0;
            end else if (state_q == e_mul_seq_calc) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << radix_bits_p;
                mplier_q <= mplier_d;
                cnt_q    <= cnt_q + 1'b1;
                if (calc_last && !flush_i) data_q <= data_d;
            end
        end
    end

endmodule

// File: tb/tb_bp_be_pipe_mul_seq.sv
// Scoreboard bench for bp_be_pipe_mul_seq: directed plan items, then random traffic vs. an arithmetic model.
module tb_bp_be_pipe_mul_seq;
    import bp_be_pkg::*;

    localparam int W = 64, R = 2, WW = 32;

    logic clk = 1'b0;
    logic reset_n, v_i, opw_i, flush_i, yumi_i, ready_and_o, v_o;
    bp_be_mul_seq_op_e op_i;
    logic [W-1:0] rs1_i, rs2_i, data_o;

    int errors = 0, checks = 0;
    logic [W-1:0] exp_q[$];
    bit yumi_en = 1'b1, yumi_rand = 1'b0;

    always #5 clk = ~clk;

    bp_be_pipe_mul_seq #(.width_p(W), .radix_bits_p(R), .word_width_p(WW)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_and_o(ready_and_o),
        .op_i(op_i), .opw_i(opw_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
        .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact integer product of the operands interpreted per RV64M.
    function automatic logic [W-1:0] ref_mul(bp_be_mul_seq_op_e op, logic opw, logic [W-1:0] a, logic [W-1:0] b);
        logic signed [2*W+1:0] sa, sb, p;
        logic s1, s2;
        if (opw) begin
            sa = {{(W+34){a[WW-1]}}, a[WW-1:0]};
            sb = {{(W+34){b[WW-1]}}, b[WW-1:0]};
            p  = sa * sb;
            return {{(W-WW){p[WW-1]}}, p[WW-1:0]};
        end
        s1 = (op == e_mulh) || (op == e_mulhsu);
        s2 = (op == e_mulh);
        sa = {{(W+2){a[W-1] & s1}}, a};
        sb = {{(W+2){b[W-1] & s2}}, b};
        p  = sa * sb;
        return (op == e_mul_lo) ? p[W-1:0] : p[2*W-1:W];
    endfunction

    // Cycles from handshake to v_o: fixed digit count, or significant multiplier digits with early out.
    function automatic int ref_lat(bp_be_mul_seq_op_e op, logic opw, logic [W-1:0] b);
        logic [W-1:0] m;
        int d;
        m = opw ? {{(W-WW){b[WW-1]}}, b[WW-1:0]} : b;
        if (opw ? b[WW-1] : (op == e_mulh && b[W-1])) m = -m;
        d = 0;
        while (m != 0) begin m = m >> R; d++; end
        if (d == 0) d = 1;
`ifdef BP_BE_MUL_SEQ_EARLY_OUT_EN
        return d + 1;
`else
        return (opw ? WW / R : W / R) + 1;
`endif
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(6))
            0: return '0;
            1: return 64'd1;
            2: return '1;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h7FFF_FFFF_FFFF_FFFF;
            5: return 64'($urandom_range(1000));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: consumes results, compares against the scoreboard, drops entries killed by flush.
    initial begin
        yumi_i = 1'b0;
        forever begin
            @(negedge clk);
            yumi_i = 1'b0;
            if (flush_i && reset_n) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (v_o && yumi_en && (!yumi_rand || $urandom_range(3) != 0)) begin
                yumi_i = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_v_o: data_o=%h with no outstanding request", data_o);
                end else begin
                    check("data_o", data_o, exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input bp_be_mul_seq_op_e op, input logic opw, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp);
        int n = 0;
        while (!ready_and_o && n < 200) begin @(posedge clk); #1; n++; end
        check("issue_ready", {63'd0, ready_and_o}, 64'd1);
        op_i = op; opw_i = opw; rs1_i = a; rs2_i = b; v_i = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        v_i = 1'b0;
    endtask

    task automatic wait_v(output int lat);
        lat = 1;
        while (lat < 200) begin
            @(negedge clk);
            if (v_o) break;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string name, input bp_be_mul_seq_op_e op, input logic opw,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
        int lat;
        issue(op, opw, a, b, exp);
        wait_v(lat);
        check_int({name, "_lat"}, lat, ref_lat(op, opw, b));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        bit seen;
        v_i = 1'b0; flush_i = 1'b0; opw_i = 1'b0; op_i = e_mul_lo; rs1_i = '0; rs2_i = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {63'd0, ready_and_o}, 64'd0);
        check("rst_v_o", {63'd0, v_o}, 64'd0);
        check("rst_data", data_o, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1 check("rel_ready_before_edge", {63'd0, ready_and_o}, 64'd0);
        @(posedge clk); #1;
        check("rel_ready_after_edge", {63'd0, ready_and_o}, 64'd1);

        run("mul_3_m5", e_mul_lo, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
        run("mulhu", e_mulhu, 1'b0, '1, 64'd2, 64'd1);
        run("mulh", e_mulh, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run("mulhsu", e_mulhsu, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run("mulw", e_mul_lo, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        run("mul_5_1", e_mul_lo, 1'b0, 64'd5, 64'd1, 64'd5);
        run("mul_5_0", e_mul_lo, 1'b0, 64'd5, 64'd0, 64'd0);
        run("mul_msb_1", e_mul_lo, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000);

        // Result held while consumer stalls.
        yumi_en = 1'b0;
        issue(e_mul_lo, 1'b0, 64'd9, 64'd9, 64'd81);
        wait_v(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_v_o", {63'd0, v_o}, 64'd1);
            check("hold_data", data_o, 64'd81);
            check("hold_ready", {63'd0, ready_and_o}, 64'd0);
        end
        yumi_en = 1'b1;
        for (int i = 0; i < 5 && v_o; i++) begin @(posedge clk); #1; end

        // Flush mid-CALC: the killed op must never present a result.
        issue(e_mul_lo, 1'b0, 64'h1234_5678_9ABC_DEF0, '1, 64'd0);
        repeat (9) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; seen |= v_o; end
        check("flush_no_v_o", {63'd0, seen}, 64'd0);
        run("mul_6_7", e_mul_lo, 1'b0, 64'd6, 64'd7, 64'd42);

        // Flush concurrent with request drops it.
        op_i = e_mul_lo; opw_i = 1'b0; rs1_i = 64'd11; rs2_i = 64'd3; v_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0; flush_i = 1'b0;
        check("drop_ready", {63'd0, ready_and_o}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; seen |= v_o; end
        check("drop_no_v_o", {63'd0, seen}, 64'd0);

        // Async reset mid-CALC clears everything including the last result.
        issue(e_mul_lo, 1'b0, 64'd3, '1, 64'd0);
        repeat (4) begin @(posedge clk); #1; end
        #2 reset_n = 1'b0;
        #1;
        check("arst_ready", {63'd0, ready_and_o}, 64'd0);
        check("arst_v_o", {63'd0, v_o}, 64'd0);
        check("arst_data", data_o, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("arst_ready_back", {63'd0, ready_and_o}, 64'd1);
        run("post_rst", e_mul_lo, 1'b0, 64'd6, 64'd7, 64'd42);

        // Random traffic with random stalls and flushes.
        yumi_rand = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            bp_be_mul_seq_op_e op;
            logic opw;
            logic [W-1:0] a, b;
            flush_i = ($urandom_range(49) == 0);
            v_i = 1'b0;
            if (ready_and_o && $urandom_range(2) == 0) begin
                op  = bp_be_mul_seq_op_e'($urandom_range(3));
                opw = (op == e_mul_lo) && $urandom_range(1) == 1;
                a = rand_operand(); b = rand_operand();
                op_i = op; opw_i = opw; rs1_i = a; rs2_i = b; v_i = 1'b1;
                if (!flush_i) exp_q.push_back(ref_mul(op, opw, a, b));
            end
            @(posedge clk); #1;
        end
        v_i = 1'b0; flush_i = 1'b0;
        for (int i = 0; i < 200 && (exp_q.size() > 0 || v_o); i++) begin @(posedge clk); #1; end
        check_int("drain_outstanding", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
